// File: rtl/loop_arb_pkg.sv
// rtl/loop_arb_pkg.sv - shared types and constants for the loop register arbiter
// Purpose: arbiter FSM state encoding, soft-reset register address and the
//          gap counter width helper.
// Ports:   none (package)
package loop_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RD_CAP = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    localparam int SOFT_RST_ADDR = 0;

    // Width that holds the longer of the two post-write gaps minus one.
    function automatic int gap_cnt_width(input int wr_gap, input int rst_gap);
        int m;
        m = (wr_gap > rst_gap) ? wr_gap : rst_gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/loop_rr_picker.sv
// rtl/loop_rr_picker.sv - combinational round-robin request picker
// Purpose: picks one requester starting the search at i_ptr.
//          With LOOP_ARB_PRIO_EN defined, requester 0 wins outright whenever
//          it requests and the rotating search covers requesters 1..N-1 only.
// Ports:   i_req   request vector
//          i_ptr   round-robin start index
//          o_grant one-hot grant
//          o_idx   index of the granted requester
//          o_any   at least one request present
module loop_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

`ifdef LOOP_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    int w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // i_ptr is always < NUM_REQ, so one wrap subtraction suffices
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_any && i_req[w_cand] && !(PRIO_EN && w_cand == 0)) begin
                o_any           = 1'b1;
                o_idx           = IDX_W'(w_cand);
                o_grant[w_cand] = 1'b1;
            end
        end
        if (PRIO_EN && i_req[0]) begin
            o_grant    = '0;
            o_grant[0] = 1'b1;
            o_idx      = '0;
            o_any      = 1'b1;
        end
    end

endmodule

// File: rtl/loop_reg_arbiter.sv
// rtl/loop_reg_arbiter.sv - multi-requester arbiter for the loop register bridge
// Purpose: grants one register transaction at a time onto the bridge port,
//          holds the address for read capture and inserts an idle gap after
//          every write (longer after a soft-reset register write).
//          Optional macro LOOP_ARB_PRIO_EN (in loop_rr_picker): requester 0
//          gets strict priority and the round-robin pointer skips 0.
// Ports:   reg_clk, reg_rst          clock, async active-high reset
//          req_valid/we/addr/wdata   per-requester request, sliced by index
//          req_ready                 one-cycle accept pulse to the winner
//          rsp_valid, rsp_rdata      one-cycle completion pulse, shared read data
//          busy                      FSM not idle
//          reg_en/we/addr/din        bridge request side
//          reg_dout                  bridge read data, combinational on reg_addr
module loop_reg_arbiter
    import loop_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int REG_ADDR_W = 12,
    parameter int WR_GAP     = 8,
    parameter int RST_GAP    = 24
) (
    input  logic                         reg_clk,
    input  logic                         reg_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         busy,
    output logic                         reg_en,
    output logic                         reg_we,
    output logic [REG_ADDR_W-1:0]        reg_addr,
    output logic [31:0]                  reg_din,
    input  logic [31:0]                  reg_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = gap_cnt_width(WR_GAP, RST_GAP);

`ifdef LOOP_ARB_PRIO_EN
    localparam logic [IDX_W-1:0] PTR_WRAP = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] PTR_WRAP = '0;
`endif

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win;
    logic               r_we;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic [IDX_W-1:0]   w_next_ptr;

    loop_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_next_ptr = w_idx + IDX_W'(1);
        if (int'(w_idx) == NUM_REQ - 1) begin
            w_next_ptr = PTR_WRAP;
        end
    end

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_we      <= 1'b0;
            r_gap_cnt <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            reg_en    <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_din   <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            reg_en    <= 1'b0;
            reg_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win     <= w_idx;
                        r_we      <= req_we[w_idx];
                        r_ptr     <= w_next_ptr;
                        reg_en    <= 1'b1;
                        reg_we    <= req_we[w_idx];
                        reg_addr  <= req_addr[int'(w_idx)*REG_ADDR_W +: REG_ADDR_W];
                        reg_din   <= req_wdata[int'(w_idx)*32 +: 32];
                        req_ready <= w_grant;
                        busy      <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        // reg_addr still holds the issued address
                        r_gap_cnt <= (reg_addr == REG_ADDR_W'(SOFT_RST_ADDR))
                                     ? GAP_W'(RST_GAP - 1) : GAP_W'(WR_GAP - 1);
                        r_state   <= GAP;
                    end else begin
                        r_state   <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    rsp_rdata        <= reg_dout;
                    rsp_valid[r_win] <= 1'b1;
                    busy             <= 1'b0;
                    r_state          <= IDLE;
                end
                GAP: begin
                    // Counter reaches 0 on this edge: the response pulse lands
                    // exactly WR_GAP/RST_GAP cycles after the ISSUE cycle.
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_gap_cnt        <= '0;
                        rsp_valid[r_win] <= 1'b1;
                        busy             <= 1'b0;
                        r_state          <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
